// File: rtl/coin_score_tracker.sv
// coin_score_tracker
//   Credits the one-cycle touch pulses coming from the per-coin detectors.
//   Touches that arrive together are queued and credited one at a time, so
//   each coin counts exactly once. The block keeps the coin count, score and
//   lives, awards a 1-up every COINS_PER_LIFE coins, and raises a req/ack
//   sound request towards the audio block for every credit.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   touch      bit i = one-cycle touch pulse from coin i
//   life_lost  one-cycle pulse, removes a life (saturates at 0)
//   sfx_ack    audio block accepted the current sound request
//   coin_count coins collected, 0..COINS_PER_LIFE-1
//   score      binary score, saturates at SCORE_MAX
//   lives      lives remaining, 0..MAX_LIVES
//   one_up     one-cycle pulse when a life is awarded
//   sfx_req    sound request, held until sfx_ack
//   sfx_id     0 = coin sound, 1 = 1-up sound; stable while sfx_req is high
//   game_over  high whenever lives == 0
module coin_score_tracker #(
    parameter int unsigned NUM_COINS      = 8,
    parameter int unsigned COINS_PER_LIFE = 100,
    parameter int unsigned COIN_POINTS    = 200,
    parameter int unsigned SCORE_MAX      = 999999,
    parameter int unsigned START_LIVES    = 3,
    parameter int unsigned MAX_LIVES      = 99
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_COINS-1:0] touch,
    input  logic                 life_lost,
    input  logic                 sfx_ack,
    output logic [6:0]           coin_count,
    output logic [19:0]          score,
    output logic [6:0]           lives,
    output logic                 one_up,
    output logic                 sfx_req,
    output logic                 sfx_id,
    output logic                 game_over
);

    typedef enum logic [1:0] {
        IDLE,
        CREDIT,
        SFX_WAIT
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [NUM_COINS-1:0] pending;
    logic [NUM_COINS-1:0] grant;

    logic [20:0] score_sum;
    logic [19:0] score_sat;
    logic [7:0]  count_inc;
    logic        wrap;
    logic        award;
    logic [7:0]  lives_inc;
    logic [6:0]  lives_awarded;
    logic [6:0]  lives_next;

    // Next-state logic; grant is only issued from IDLE and picks the
    // lowest pending coin (two's-complement isolate of the lowest set bit).
    always_comb begin
        state_next = state;
        grant      = '0;
        case (state)
            IDLE: begin
                if (pending != '0) begin
                    grant      = pending & (~pending + NUM_COINS'(1));
                    state_next = CREDIT;
                end
            end
            CREDIT:   state_next = SFX_WAIT;
            SFX_WAIT: if (sfx_ack) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Score is summed one bit wider than the port so the ceiling compare
    // sees the true overflow instead of a wrapped value.
    always_comb begin
        score_sum = {1'b0, score} + 21'(COIN_POINTS);
        score_sat = (score_sum > 21'(SCORE_MAX)) ? 20'(SCORE_MAX) : score_sum[19:0];
        count_inc = {1'b0, coin_count} + 8'd1;
        wrap      = (count_inc == 8'(COINS_PER_LIFE));
        award     = (state == CREDIT) && wrap;
    end

    // The award saturates first and life_lost is applied afterwards: an
    // unsaturated award plus a lost life nets to no change, while at
    // MAX_LIVES the pair nets to one life fewer.
    always_comb begin
        lives_inc     = {1'b0, lives} + 8'd1;
        lives_awarded = lives;
        if (award) begin
            lives_awarded = (lives_inc > 8'(MAX_LIVES)) ? 7'(MAX_LIVES) : lives_inc[6:0];
        end
        lives_next = lives_awarded;
        if (life_lost && (lives_awarded != '0)) begin
            lives_next = lives_awarded - 7'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending    <= '0;
            coin_count <= '0;
            score      <= '0;
            lives      <= 7'(START_LIVES);
            one_up     <= 1'b0;
            sfx_req    <= 1'b0;
            sfx_id     <= 1'b0;
        end else begin
            // A touch landing on the bit being granted re-arms it.
            pending <= (pending & ~grant) | touch;
            lives   <= lives_next;
            one_up  <= award;
            if (state == CREDIT) begin
                score      <= score_sat;
                coin_count <= wrap ? '0 : count_inc[6:0];
                sfx_id     <= wrap;
                sfx_req    <= 1'b1;
            end else if ((state == SFX_WAIT) && sfx_ack) begin
                sfx_req <= 1'b0;
            end
        end
    end

    assign game_over = (lives == '0);

endmodule
